// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types, defaults and stage-condition helper for the stage sequencer
package seq_pkg;

  localparam int SEQ_MAX_STAGES  = 16;
  localparam int SEQ_DEF_DW      = 4;
  localparam int SEQ_DEF_NF      = 3;
  localparam int SEQ_DEF_NSTAGE  = 5;
  localparam int SEQ_DEF_TIMEOUT = 16;

  // Helper operands are zero-extended to these widths; zero mask bits make the padding don't-care
  localparam int SEQ_MAX_DW = 32;
  localparam int SEQ_MAX_NF = 32;

  typedef enum logic [1:0] {
    KIND_IDLE,
    KIND_MID,
    KIND_FINAL,
    KIND_BAD
  } seq_kind_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic timeout;
  } seq_status_t;

  function automatic logic stage_match(
    input logic [SEQ_MAX_DW-1:0] d,
    input logic [SEQ_MAX_DW-1:0] cmp,
    input logic [SEQ_MAX_DW-1:0] dmask,
    input logic [SEQ_MAX_NF-1:0] flags,
    input logic [SEQ_MAX_NF-1:0] fmask
  );
    return (((d ^ cmp) & dmask) == '0) && ((flags & fmask) == fmask);
  endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// rtl/seq_timeout_cnt.sv - per-stage dwell counter; expire flags the last allowed cycle
module seq_timeout_cnt #(
  parameter int TIMEOUT = 16,
  localparam int CW = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expire = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/seq_stage_fsm.sv
// rtl/seq_stage_fsm.sv - programmable NSTAGE Moore sequencer with per-stage timeout
// Optional SEQ_ABORT_EN adds an abort input that returns to idle without a timeout pulse.
module seq_stage_fsm
  import seq_pkg::*;
#(
  parameter int DW      = SEQ_DEF_DW,
  parameter int NF      = SEQ_DEF_NF,
  parameter int NSTAGE  = SEQ_DEF_NSTAGE,
  parameter int TIMEOUT = SEQ_DEF_TIMEOUT,
  localparam int QW     = $clog2(NSTAGE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NF-1:0]      flags,
  input  logic [DW-1:0]      d,
  input  logic [NSTAGE*DW-1:0] stage_cmp,
  input  logic [NSTAGE*DW-1:0] stage_dmask,
  input  logic [NSTAGE*NF-1:0] stage_fmask,
`ifdef SEQ_ABORT_EN
  input  logic               abort,
`endif
  output logic [QW-1:0]      q,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  logic [QW-1:0] r_q;
  logic          r_timeout;
  seq_kind_t     w_kind;
  logic [DW-1:0] w_cmp;
  logic [DW-1:0] w_dmask;
  logic [NF-1:0] w_fmask;
  logic          w_match;
  logic          w_expire;
  logic          w_cnt_en;
  logic          w_cnt_clr;
  logic          w_abort;
  seq_status_t   w_status;

`ifdef SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    if (int'(r_q) >= NSTAGE)           w_kind = KIND_BAD;
    else if (r_q == '0)                w_kind = KIND_IDLE;
    else if (r_q == QW'(NSTAGE - 1))   w_kind = KIND_FINAL;
    else                               w_kind = KIND_MID;
  end

  always_comb begin
    w_cmp   = '0;
    w_dmask = '0;
    w_fmask = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (r_q == QW'(k)) begin
        w_cmp   = stage_cmp[k*DW +: DW];
        w_dmask = stage_dmask[k*DW +: DW];
        w_fmask = stage_fmask[k*NF +: NF];
      end
    end
  end

  assign w_match = stage_match(SEQ_MAX_DW'(d), SEQ_MAX_DW'(w_cmp), SEQ_MAX_DW'(w_dmask),
                               SEQ_MAX_NF'(flags), SEQ_MAX_NF'(w_fmask));

  // Clear whenever q is about to change so every stage starts its dwell from zero
  assign w_cnt_clr = w_abort || (w_kind == KIND_BAD) ||
                     (en && ((w_kind == KIND_FINAL) ||
                             ((w_kind == KIND_IDLE) && w_match) ||
                             ((w_kind == KIND_MID) && (w_match || w_expire))));
  assign w_cnt_en  = en && (w_kind == KIND_MID) && !w_match;

  seq_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_cnt_clr),
    .en     (w_cnt_en),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst || w_abort) begin
      r_q       <= '0;
      r_timeout <= 1'b0;
    end else if (w_kind == KIND_BAD) begin
      r_q       <= '0;
      r_timeout <= 1'b0;
    end else if (!en) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      unique case (w_kind)
        KIND_IDLE: if (w_match) r_q <= QW'(1);
        KIND_MID: begin
          if (w_match) begin
            r_q <= r_q + QW'(1);
          end else if (w_expire) begin
            r_q       <= '0;
            r_timeout <= 1'b1;
          end
        end
        default: r_q <= '0;
      endcase
    end
  end

  assign w_status = '{busy: (r_q != '0), done: (r_q == QW'(NSTAGE - 1)), timeout: r_timeout};

  assign q       = r_q;
  assign busy    = w_status.busy;
  assign done    = w_status.done;
  assign timeout = w_status.timeout;

endmodule
